lsu_mem_ctrl: RTL

//   MEM-stage load/store controller between the pipeline and the data memory port.

---
 rtl/lsu_mem_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl : MEM-stage load/store controller (dmem req/gnt/rvalid handshake).
// Optional: define MISALIGN_TRAP_EN to fault misaligned accesses without a bus cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_mem_pkg;
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'b000,
    MEM_HALF   = 3'b001,
    MEM_WORD   = 3'b010,
    MEM_BYTE_U = 3'b100,
    MEM_HALF_U = 3'b101
  } mem_op_e;
endpackage

module lsu_mem_ctrl
  import lsu_mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic            req_is_store_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  mem_op_e         req_mem_op_i,
  output logic            stall_o,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_raw_o,
  output logic [XLEN-1:0] resp_addr_o,
  output mem_op_e         resp_mem_op_o,
  output logic            resp_err_o,
  output logic            dmem_req_o,
  input  logic            dmem_gnt_i,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  mem_op_e           op_q, op_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   resp_addr_q, resp_addr_d;
  mem_op_e           resp_op_q, resp_op_d;

  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [CNT_W-1:0]  w_cnt_inc;

  // Lane steering: narrow stores are replicated so every enabled lane sees the data.
  always_comb begin
    w_be    = 4'hF << req_addr_i[1:0];
    w_wdata = req_wdata_i;
    case (req_mem_op_i)
      MEM_BYTE, MEM_BYTE_U: begin
        w_be    = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      MEM_HALF, MEM_HALF_U: begin
        w_be    = 4'b0011 << {req_addr_i[1], 1'b0};
        w_wdata = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;

  always_comb begin
    w_misaligned = 1'b0;
    case (req_mem_op_i)
      MEM_HALF, MEM_HALF_U: w_misaligned = req_addr_i[0];
      MEM_WORD:             w_misaligned = |req_addr_i[1:0];
      default:              w_misaligned = 1'b0;
    endcase
  end
`endif

  assign w_cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    op_d         = op_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    resp_addr_d  = resp_addr_q;
    resp_op_d    = resp_op_q;
    dmem_req_o   = 1'b0;
    resp_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          op_d    = req_mem_op_i;
          we_d    = req_is_store_i;
          be_d    = w_be;
          wdata_d = w_wdata;
          state_d = S_REQ;
`ifdef MISALIGN_TRAP_EN
          if (w_misaligned) begin
            state_d     = S_RESP;
            err_d       = 1'b1;
            rdata_d     = '0;
            resp_addr_d = req_addr_i;
            resp_op_d   = req_mem_op_i;
          end
`endif
        end
      end
      S_REQ: begin
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d     = S_RESP;
          err_d       = 1'b0;
          rdata_d     = we_q ? '0 : dmem_rdata_i;
          resp_addr_d = addr_q;
          resp_op_d   = op_q;
          cnt_d       = '0;
        end else if (TO_EN && (w_cnt_inc == TO_VAL)) begin
          state_d     = S_RESP;
          err_d       = 1'b1;
          rdata_d     = '0;
          resp_addr_d = addr_q;
          resp_op_d   = op_q;
          cnt_d       = '0;
        end else begin
          cnt_d = TO_EN ? w_cnt_inc : '0;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      op_q        <= MEM_BYTE;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      resp_addr_q <= '0;
      resp_op_q   <= MEM_BYTE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      resp_addr_q <= resp_addr_d;
      resp_op_q   <= resp_op_d;
    end
  end

  // The pipeline is released in the RESP cycle so it advances on that edge.
  assign stall_o          = req_valid_i & (state_q != S_RESP);
  assign resp_err_o       = (state_q == S_RESP) & err_q;
  assign resp_rdata_raw_o = rdata_q;
  assign resp_addr_o      = resp_addr_q;
  assign resp_mem_op_o    = resp_op_q;
  assign dmem_we_o        = (state_q == S_REQ) & we_q;
  assign dmem_addr_o      = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_be_o        = be_q;
  assign dmem_wdata_o     = wdata_q;

endmodule

`default_nettype wire
